// File: rtl/vram_arbiter.sv
// Single-port frame-buffer scheduler: VGA display fetch > clear engine > round-robin writers.
// Optional hardware clear engine is built when VRAM_CLEAR_EN is defined.
module vram_arbiter #(
  parameter int FB_WIDTH   = 160,
  parameter int FB_HEIGHT  = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int H_OFFSET   = 48,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              video_on,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [PIX_W-1:0]  rgb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  input  logic              wr0_valid,
  output logic              wr0_ready,
  input  logic [7:0]        wr0_x,
  input  logic [6:0]        wr0_y,
  input  logic [PIX_W-1:0]  wr0_data,
  input  logic              wr1_valid,
  output logic              wr1_ready,
  input  logic [7:0]        wr1_x,
  input  logic [6:0]        wr1_y,
  input  logic [PIX_W-1:0]  wr1_data,
  input  logic              clr_start,
  input  logic [PIX_W-1:0]  clr_color,
  output logic              clr_busy,
  output logic [15:0]       drop_count
);

  localparam logic [ADDR_W-1:0] FB_W_A  = ADDR_W'(FB_WIDTH);
  localparam logic [7:0]        FB_W_X  = 8'(FB_WIDTH);
  localparam logic [6:0]        FB_H_Y  = 7'(FB_HEIGHT);

  // Display address generation
  logic [9:0]        w_col;
  logic [9:0]        w_fx;
  logic [9:0]        w_fy;
  logic [ADDR_W-1:0] w_disp_addr;
  logic              w_disp_req;

  logic              r_von_prev;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_fetch_d1;
  logic              r_von_d1;
  logic              r_von_d2;
  logic [PIX_W-1:0]  r_pixel;

  assign w_col       = x - 10'(H_OFFSET);
  assign w_fx        = w_col >> SCALE_LOG2;
  assign w_fy        = y >> SCALE_LOG2;
  assign w_disp_addr = ADDR_W'(w_fy) * FB_W_A + ADDR_W'(w_fx);
  assign w_disp_req  = video_on && (!r_von_prev || (w_disp_addr != r_last_addr));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_von_prev  <= 1'b0;
      r_last_addr <= '1;
      r_fetch_d1  <= 1'b0;
      r_von_d1    <= 1'b0;
      r_von_d2    <= 1'b0;
      r_pixel     <= '0;
    end else begin
      r_von_prev <= video_on;
      if (w_disp_req) r_last_addr <= w_disp_addr;
      r_fetch_d1 <= w_disp_req;
      r_von_d1   <= video_on;
      r_von_d2   <= r_von_d1;
      if (r_fetch_d1) r_pixel <= mem_rdata;
    end
  end

  assign rgb = r_von_d2 ? r_pixel : '0;

  // Clear engine
  logic              w_clr_busy;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [PIX_W-1:0]  w_clr_color;

`ifdef VRAM_CLEAR_EN
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  typedef enum logic {S_IDLE, S_CLEAR} clr_state_t;
  clr_state_t        r_state;
  clr_state_t        w_state_next;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [PIX_W-1:0]  r_clr_color;

  // NOTE: combinational blocks assign defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (clr_start) w_state_next = S_CLEAR;
      S_CLEAR: if (!w_disp_req && (r_clr_addr == FB_LAST)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_clr_addr  <= '0;
      r_clr_color <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && clr_start) begin
        r_clr_addr  <= '0;
        r_clr_color <= clr_color;
      end else if ((r_state == S_CLEAR) && !w_disp_req) begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end
    end
  end

  assign w_clr_busy  = (r_state == S_CLEAR);
  assign w_clr_addr  = r_clr_addr;
  assign w_clr_color = r_clr_color;
`else
  logic w_unused_clr;
  assign w_unused_clr = &{1'b0, clr_start, clr_color};
  assign w_clr_busy   = 1'b0;
  assign w_clr_addr   = '0;
  assign w_clr_color  = '0;
`endif

  assign clr_busy = w_clr_busy;

  // Write ports: round-robin grant, then gated by the higher-priority users
  logic              r_last;
  logic [15:0]       r_drop_count;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_ok0;
  logic              w_ok1;
  logic [ADDR_W-1:0] w_wr0_addr;
  logic [ADDR_W-1:0] w_wr1_addr;
  logic              w_drop;

  assign w_gnt0    = wr0_valid && (!wr1_valid || r_last);
  assign w_gnt1    = wr1_valid && (!wr0_valid || !r_last);
  assign wr0_ready = w_gnt0 && !w_disp_req && !w_clr_busy;
  assign wr1_ready = w_gnt1 && !w_disp_req && !w_clr_busy;

  assign w_ok0      = (wr0_x < FB_W_X) && (wr0_y < FB_H_Y);
  assign w_ok1      = (wr1_x < FB_W_X) && (wr1_y < FB_H_Y);
  assign w_wr0_addr = ADDR_W'(wr0_y) * FB_W_A + ADDR_W'(wr0_x);
  assign w_wr1_addr = ADDR_W'(wr1_y) * FB_W_A + ADDR_W'(wr1_x);
  assign w_drop     = (wr0_ready && !w_ok0) || (wr1_ready && !w_ok1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_last       <= 1'b1;
      r_drop_count <= '0;
    end else begin
      if (wr0_ready)      r_last <= 1'b0;
      else if (wr1_ready) r_last <= 1'b1;
      if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;

  // Single RAM access per cycle; dropped writes leave the bus idle
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (w_disp_req) begin
      mem_addr = w_disp_addr;
    end else if (w_clr_busy) begin
      mem_addr  = w_clr_addr;
      mem_we    = 1'b1;
      mem_wdata = w_clr_color;
    end else if (wr0_ready && w_ok0) begin
      mem_addr  = w_wr0_addr;
      mem_we    = 1'b1;
      mem_wdata = wr0_data;
    end else if (wr1_ready && w_ok1) begin
      mem_addr  = w_wr1_addr;
      mem_we    = 1'b1;
      mem_wdata = wr1_data;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency frame-buffer RAM.
// Clear-engine steps are compiled only when VRAM_CLEAR_EN is defined.
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        video_on;
  logic [9:0]  x, y;
  logic [7:0]  rgb;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        wr0_valid, wr0_ready, wr1_valid, wr1_ready;
  logic [7:0]  wr0_x, wr1_x;
  logic [6:0]  wr0_y, wr1_y;
  logic [7:0]  wr0_data, wr1_data;
  logic        clr_start;
  logic [7:0]  clr_color;
  logic        clr_busy;
  logic [15:0] drop_count;

  logic [7:0]  ram [0:32767];

  int tests = 0;
  int fails = 0;

  vram_arbiter dut (
    .clock(clock), .reset(reset), .video_on(video_on), .x(x), .y(y), .rgb(rgb),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_x(wr0_x), .wr0_y(wr0_y), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_x(wr1_x), .wr1_y(wr1_y), .wr1_data(wr1_data),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] pix [0:2];
    int n;
    int bad;
    pix[0] = 8'h11; pix[1] = 8'h22; pix[2] = 8'h33;
    for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33;

    reset = 1'b0; video_on = 1'b0; x = '0; y = '0;
    wr0_valid = 1'b0; wr0_x = '0; wr0_y = '0; wr0_data = '0;
    wr1_valid = 1'b0; wr1_x = '0; wr1_y = '0; wr1_data = '0;
    clr_start = 1'b0; clr_color = '0;
    repeat (3) next_cycle();
    reset = 1'b1;

    // Quiet after reset
    for (int i = 0; i < 4; i++) begin
      next_cycle(); #1;
      check("rst_rgb", rgb, 0);
      check("rst_clr_busy", clr_busy, 0);
      check("rst_drop", drop_count, 0);
      check("rst_we", mem_we, 0);
    end

    // Display fetch from x=48 with a competing writer at (100,100)
    wr0_valid = 1'b1; wr0_x = 8'd100; wr0_y = 7'd100; wr0_data = 8'h5A;
    for (int cyc = 0; cyc < 20; cyc++) begin
      next_cycle();
      video_on = 1'b1; x = 10'(48 + cyc / 2); y = 10'd0;
      #1;
      check("disp_ready", wr0_ready, (cyc % 8) != 0);
      if ((cyc % 8) == 0) check("disp_addr", mem_addr, cyc / 8);
      check("disp_rgb", rgb, (cyc < 2) ? 8'h00 : pix[(cyc - 2) / 8]);
    end
    next_cycle(); video_on = 1'b0; wr0_valid = 1'b0; #1;
    check("blank_rgb_d2", rgb, 8'h33);
    repeat (2) next_cycle(); #1;
    check("blank_rgb", rgb, 0);

    // Round-robin in blanking after a fresh reset
    next_cycle(); reset = 1'b0;
    next_cycle(); reset = 1'b1;
    wr0_valid = 1'b1; wr0_x = 8'd3; wr0_y = 7'd5; wr0_data = 8'hA1;
    wr1_valid = 1'b1; wr1_x = 8'd7; wr1_y = 7'd9; wr1_data = 8'hB2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready0", wr0_ready, (i % 2) == 0);
      check("rr_ready1", wr1_ready, (i % 2) == 1);
      check("rr_addr", mem_addr, ((i % 2) == 0) ? 803 : 1447);
      next_cycle();
    end
    wr0_valid = 1'b0; wr1_valid = 1'b0;
    #1;
    check("rr_ram0", ram[803], 8'hA1);
    check("rr_ram1", ram[1447], 8'hB2);

    // Range check and drop counter
    next_cycle();
    wr0_valid = 1'b1; wr0_x = 8'd160; wr0_y = 7'd5; #1;
    check("drop_ready", wr0_ready, 1);
    check("drop_we", mem_we, 0);
    next_cycle();
    wr0_x = 8'd0; wr0_y = 7'd120; #1;
    check("drop_cnt1", drop_count, 1);
    check("drop_we_y", mem_we, 0);
    next_cycle();
    wr0_x = 8'd159; wr0_y = 7'd119; wr0_data = 8'h3C; #1;
    check("drop_cnt2", drop_count, 2);
    check("edge_we", mem_we, 1);
    check("edge_addr", mem_addr, 19199);
    next_cycle();
    wr0_valid = 1'b0; #1;
    check("edge_no_drop", drop_count, 2);
    check("edge_ram", ram[19199], 8'h3C);
    wr0_valid = 1'b1; wr0_x = 8'd200;
    repeat (65540) next_cycle();
    wr0_valid = 1'b0;
    next_cycle(); #1;
    check("drop_sat", drop_count, 16'hFFFF);

    // Clear command
    wr0_valid = 1'b1; wr0_x = 8'd1; wr0_y = 7'd1; wr0_data = 8'h77;
    clr_start = 1'b1; clr_color = 8'hE0;
    next_cycle();
    clr_start = 1'b0; clr_color = 8'h00; #1;
`ifdef VRAM_CLEAR_EN
    check("clr_busy_on", clr_busy, 1);
    check("clr_block", wr0_ready, 0);
    n = 0; bad = 0;
    while (clr_busy && n < 30000) begin
      if (wr0_ready) bad++;
      next_cycle(); #1;
      n++;
    end
    check("clr_cycles", n, 19200);
    check("clr_ready_seen", bad, 0);
    bad = 0;
    for (int i = 0; i < 19200; i++) if (ram[i] !== 8'hE0) bad++;
    check("clr_ram", bad, 0);
    check("clr_ready_after", wr0_ready, 1);

    // Reset mid-clear
    next_cycle(); clr_start = 1'b1; clr_color = 8'h1F;
    next_cycle(); clr_start = 1'b0;
    repeat (100) next_cycle();
    #1; check("mid_busy", clr_busy, 1);
    next_cycle(); reset = 1'b0;
    next_cycle(); reset = 1'b1; #1;
    check("mid_rst_busy", clr_busy, 0);
    check("mid_rst_ready", wr0_ready, 1);
`else
    check("noclr_busy", clr_busy, 0);
    check("noclr_ready", wr0_ready, 1);
    check("noclr_we", mem_we, 1);
    check("noclr_data", mem_wdata, 8'h77);
`endif
    wr0_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video-memory scheduler between the VGA scan-out and two GPU pixel writers. Uses `video_on`, `x` and `y` from the VGA sync generator to issue display reads at fixed priority. Spare cycles go round-robin to two valid/ready write ports, or to an optional hardware clear engine. Sits between the sync generator, the rasterizer/host write paths and a synchronous single-port frame-buffer RAM with 1-cycle read latency.

## Interface
- `FB_WIDTH`, 160, frame-buffer columns
- `FB_HEIGHT`, 120, frame-buffer rows
- `SCALE_LOG2`, 2, log2 of screen pixels per frame-buffer pixel, applied to both axes
- `H_OFFSET`, 48, `x` value of the first visible column
- `PIX_W`, 8, pixel width (RGB332)
- `ADDR_W`, 15, RAM address width
- `clock  in  1  system clock (2× pixel rate)`
- `reset  in  1  synchronous, active-low`
- `video_on  in  1  visible-area flag from sync generator`
- `x, y  in  10 each  current scan counters`
- `rgb  out  PIX_W  registered pixel to DAC; 0 in blanking`
- `mem_addr  out  ADDR_W  RAM address (combinational)`
- `mem_we  out  1  RAM write enable (combinational)`
- `mem_wdata  out  PIX_W  RAM write data`
- `mem_rdata  in  PIX_W  RAM read data, valid 1 cycle after address`
- `wrN_valid  in  1  write request, N∈{0,1}`
- `wrN_ready  out  1  write accepted this cycle`
- `wrN_x  in  8  target column`
- `wrN_y  in  7  target row`
- `wrN_data  in  PIX_W  pixel value`
- `clr_start  in  1  one-cycle clear command`
- `clr_color  in  PIX_W  clear colour, sampled with `clr_start``
- `clr_busy  out  1  clear in progress`
- `drop_count  out  16  saturating count of out-of-range writes`

## Operation
- Display address:
  - col = x − H_OFFSET (10-bit, wraps).
  - fx = col >> SCALE_LOG2; fy = y >> SCALE_LOG2.
  - disp_addr = fy·FB_WIDTH + fx, truncated to ADDR_W.
- Display fetch (`disp_req`) fires when `video_on`=1 and either:
  - `video_on` was 0 in the previous cycle, or
  - disp_addr ≠ last_addr.
  - On a fetch, last_addr ← disp_addr. Reset value of last_addr is all ones.
- Priority each cycle: display fetch > clear engine > write ports. Exactly one RAM access per cycle.
- Write ports:
  - Arbitration is round-robin. Pointer `last` resets to 1, so port 0 wins the first conflict.
  - When both ports are valid, the port ≠ `last` is granted. `last` updates only on an accepted transfer.
  - wrN_ready = granted ∧ ¬disp_req ∧ ¬clr_busy. Ready may depend combinationally on valid.
- Range check on a write: wrN_x ≥ FB_WIDTH or wrN_y ≥ FB_HEIGHT.
  - The write is still accepted (ready=1), but `mem_we` stays 0.
  - drop_count increments, saturating at 0xFFFF.
  - In-range writes use addr = y·FB_WIDTH + x.
- Clear FSM:
  - IDLE: `clr_start` latches `clr_color`, sets clr_addr=0, and moves to CLEAR. `clr_start` is ignored outside IDLE.
  - CLEAR: in every cycle without `disp_req`, write the latched colour to clr_addr, then clr_addr++.
  - After writing FB_WIDTH·FB_HEIGHT−1, return to IDLE.
- Idle cycles: mem_we=0, mem_addr=0, mem_wdata=0.
- Reset values: rgb=0, clr_busy=0, drop_count=0, FSM=IDLE, last=1, pipeline flags=0.

## Timing
- Fetch issued in cycle t; `mem_rdata` is captured into the pixel register at the end of t+1; `rgb` shows that pixel from t+2.
- `video_on` is delayed 2 cycles. `rgb` = pixel register when the delayed flag is 1, else 0. This gives a fixed 2-clock (1 screen pixel) shift.
- With SCALE_LOG2=2, the display takes at most 1 slot per 8 clocks during active video. Blanking leaves all slots to writers/clear.
- Write handshake completes in the cycle valid ∧ ready. Data must be held stable while valid ∧ ¬ready.
- Clear of 19200 pixels finishes in ≥19200 cycles, plus one cycle per display fetch stolen.
- Reset asserted mid-clear: FSM returns to IDLE. RAM contents are left partially cleared.

## Configuration
- `VRAM_CLEAR_EN` defined: clear FSM present as above.
- Not defined: `clr_start`/`clr_color` ignored, `clr_busy` tied 0, clear priority level removed. Ports remain in the interface.

## Test plan
- After reset with no requests: rgb=0, clr_busy=0, drop_count=0, mem_we=0 in every cycle.
- x=48, y=0, video_on rising → disp_req, mem_addr=0. x=52 → mem_addr=1. x=56 → mem_addr=2. rgb equals the RAM data 2 cycles after each fetch.
- Both ports valid continuously during blanking → grants alternate 0,1,0,1. During active video, ready=0 in every disp_req cycle.
- wr0_x=160, wr0_y=5 → ready=1, mem_we=0, drop_count=1. After 70000 such writes, drop_count holds at 65535.
- With `VRAM_CLEAR_EN`, clr_start with colour 0xE0 → clr_busy=1; every RAM word reads 0xE0 afterwards; write ports ready=0 until clr_busy falls.
- Reset pulsed mid-clear → clr_busy=0 the next cycle, and write ports are granted again.
